// File: rtl/onewire_pkg.sv
// Shared op codes, FSM states and slot timing (in microseconds) for the 1-wire engine.
package onewire_pkg;

    typedef enum logic [1:0] {
        OP_RESET      = 2'd0,
        OP_WRITE_BYTE = 2'd1,
        OP_READ_BYTE  = 2'd2,
        OP_TOUCH_BIT  = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RST_LOW,
        RST_WAIT,
        RST_RECOVER,
        SLOT_LOW,
        SLOT_SAMPLE,
        SLOT_RECOVER,
        DONE
    } state_t;

    localparam int RESET_LOW_US       = 480;
    localparam int PRESENCE_SAMPLE_US = 70;
    localparam int RESET_RECOVER_US   = 410;
    localparam int SLOT_LOW1_US       = 6;
    localparam int SLOT_LOW0_US       = 60;
    localparam int SAMPLE_US          = 9;
    localparam int SLOT_US            = 70;
    localparam int RECOVERY_US        = 1;

    // Recovery length that pads a slot out to SLOT_US plus the inter-slot gap.
    function automatic logic [9:0] slotRecoverUs(input logic writeOne);
        if (writeOne)
            return 10'(SLOT_US + RECOVERY_US - SLOT_LOW1_US - SAMPLE_US);
        return 10'(SLOT_US + RECOVERY_US - SLOT_LOW0_US);
    endfunction

endpackage

// File: rtl/onewire_if.sv
// Host command/response bundle of the 1-wire engine; master is the register glue, slave the engine.
interface onewire_if #(
    parameter int CHANNEL_BITS = 3
);
    import onewire_pkg::*;

    logic                    cmdValid;
    logic                    cmdReady;
    op_t                     cmdOp;
    logic [CHANNEL_BITS-1:0] cmdChannel;
    logic [7:0]              cmdData;
    logic                    respValid;
    logic [7:0]              respData;
    logic                    respPresence;
    logic                    respError;

    modport master (
        output cmdValid, cmdOp, cmdChannel, cmdData,
        input  cmdReady, respValid, respData, respPresence, respError
    );

    modport slave (
        input  cmdValid, cmdOp, cmdChannel, cmdData,
        output cmdReady, respValid, respData, respPresence, respError
    );

endinterface

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler: one-cycle tick every US_CYCLES clocks, first tick US_CYCLES after restart.
module onewire_us_tick #(
    parameter int CLOCK_FREQ = 29491200
) (
    input  logic clock29M,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int US_CYCLES = CLOCK_FREQ / 1000000;
    localparam int CW        = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(US_CYCLES - 1));

    always_ff @(posedge clock29M) begin
        if (reset || restart || tick) count <= '0;
        else                          count <= count + CW'(1);
    end

endmodule

// File: rtl/onewire_master.sv
// 1-wire timing engine: one command at a time on one channel, all slot timing generated here.
// Single outstanding command; cmdReady low from acceptance until the cycle after respValid.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int CLOCK_FREQ   = 29491200,
    parameter int CHANNEL_BITS = 3
) (
    input  logic                clock29M,
    input  logic                reset,
    onewire_if.slave            host,
    output logic [CHANNELS-1:0] busDriveLow,
    input  logic [CHANNELS-1:0] busIn
);
    state_t                  state, stateNext;
    op_t                     opReg;
    logic [CHANNEL_BITS-1:0] chanReg;
    logic [7:0]              dataReg, shiftReg, respData;
    logic                    chanOk, respPresence, respError;
    logic [2:0]              bitIndex;
    logic [9:0]              usCount, phaseLen;
    logic [CHANNELS-1:0]     busMeta, busSync;
    logic                    busSel, driving, tick, accept, phaseDone, txBit, lastBit;

    assign accept            = (state == IDLE) && host.cmdValid;
    assign host.cmdReady     = (state == IDLE);
    assign host.respValid    = (state == DONE);
    assign host.respData     = respData;
    assign host.respPresence = respPresence;
    assign host.respError    = respError;

    onewire_us_tick #(.CLOCK_FREQ(CLOCK_FREQ)) usTick (
        .clock29M (clock29M),
        .reset    (reset),
        .restart  (accept),
        .tick     (tick)
    );

    // Pads idle high, so the synchroniser resets to the released level.
    always_ff @(posedge clock29M) begin
        if (reset) begin
            busMeta <= '1;
            busSync <= '1;
        end else begin
            busMeta <= busIn;
            busSync <= busMeta;
        end
    end

    always_comb begin
        driving     = (state == RST_LOW) || (state == SLOT_LOW);
        busSel      = 1'b1;
        busDriveLow = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chanReg == CHANNEL_BITS'(i)) begin
                busSel         = busSync[i];
                busDriveLow[i] = driving;
            end
        end
    end

    assign txBit     = (opReg == OP_READ_BYTE) ? 1'b1 : dataReg[bitIndex];
    assign lastBit   = (opReg == OP_TOUCH_BIT) || (bitIndex == 3'd7);
    assign phaseDone = tick && (usCount == phaseLen - 10'd1);

    always_comb begin
        phaseLen = 10'd1;
        case (state)
            RST_LOW:      phaseLen = 10'(RESET_LOW_US);
            RST_WAIT:     phaseLen = 10'(PRESENCE_SAMPLE_US);
            RST_RECOVER:  phaseLen = 10'(RESET_RECOVER_US);
            SLOT_LOW:     phaseLen = txBit ? 10'(SLOT_LOW1_US) : 10'(SLOT_LOW0_US);
            SLOT_SAMPLE:  phaseLen = 10'(SAMPLE_US);
            SLOT_RECOVER: phaseLen = slotRecoverUs(txBit);
            default:      phaseLen = 10'd1;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:         if (host.cmdValid) stateNext = CHECK;
            // Valid channels wait for the first tick so every phase starts on a tick boundary.
            CHECK: begin
                if (!chanOk)                  stateNext = DONE;
                else if (tick) begin
                    if (opReg != OP_RESET)    stateNext = SLOT_LOW;
                    else if (busSel)          stateNext = RST_LOW;
                    else                      stateNext = DONE;
                end
            end
            RST_LOW:      if (phaseDone) stateNext = RST_WAIT;
            RST_WAIT:     if (phaseDone) stateNext = RST_RECOVER;
            RST_RECOVER:  if (phaseDone) stateNext = DONE;
            SLOT_LOW:     if (phaseDone) stateNext = txBit ? SLOT_SAMPLE : SLOT_RECOVER;
            SLOT_SAMPLE:  if (phaseDone) stateNext = SLOT_RECOVER;
            SLOT_RECOVER: if (phaseDone) stateNext = lastBit ? DONE : SLOT_LOW;
            DONE:         stateNext = IDLE;
            default:      stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock29M) begin
        if (reset) begin
            state        <= IDLE;
            opReg        <= OP_RESET;
            chanReg      <= '0;
            dataReg      <= '0;
            chanOk       <= 1'b0;
            bitIndex     <= '0;
            usCount      <= '0;
            shiftReg     <= '0;
            respData     <= '0;
            respPresence <= 1'b0;
            respError    <= 1'b0;
        end else begin
            state <= stateNext;
            if (stateNext != state) usCount <= '0;
            else if (tick)          usCount <= usCount + 10'd1;

            case (state)
                IDLE: if (accept) begin
                    opReg        <= host.cmdOp;
                    chanReg      <= host.cmdChannel;
                    dataReg      <= host.cmdData;
                    chanOk       <= 32'(host.cmdChannel) < CHANNELS;
                    bitIndex     <= '0;
                    shiftReg     <= '0;
                    respPresence <= 1'b0;
                    respError    <= 1'b0;
                end
                CHECK:        if (!chanOk || (tick && opReg == OP_RESET && !busSel)) respError <= 1'b1;
                RST_WAIT:     if (phaseDone) respPresence <= ~busSel;
                // A write-0 slot holds the line itself, so its result is known to be 0.
                SLOT_LOW:     if (phaseDone && !txBit) shiftReg <= {1'b0, shiftReg[7:1]};
                SLOT_SAMPLE:  if (phaseDone) shiftReg <= {busSel, shiftReg[7:1]};
                SLOT_RECOVER: if (phaseDone) bitIndex <= bitIndex + 3'd1;
                default: ;
            endcase

            if (stateNext == DONE && state != DONE)
                respData <= (opReg == OP_TOUCH_BIT) ? {7'b0, shiftReg[7]} : shiftReg;
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Randomised bench for onewire_master with a behavioural bus/slave model and result model.
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int CHANNELS     = 2;
    localparam int CHANNEL_BITS = 3;
    localparam int CLOCK_FREQ   = 8_900_000;
    localparam int US           = CLOCK_FREQ / 1000000;

    logic                clock29M = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] busDriveLow, busIn, slavePull, forceLow;

    onewire_if #(.CHANNEL_BITS(CHANNEL_BITS)) host ();

    onewire_master #(
        .CHANNELS     (CHANNELS),
        .CLOCK_FREQ   (CLOCK_FREQ),
        .CHANNEL_BITS (CHANNEL_BITS)
    ) dut (
        .clock29M    (clock29M),
        .reset       (reset),
        .host        (host),
        .busDriveLow (busDriveLow),
        .busIn       (busIn)
    );

    // Wired-AND open-drain bus: master, slave or a forced short can pull it low.
    assign busIn = ~(busDriveLow | slavePull | forceLow);

    always #5 clock29M = ~clock29M;

    int cyc = 0;
    always @(posedge clock29M) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         monSel = 0;
    int         pulseQ[$];
    int         fallQ[$];
    int         otherDrive = 0;
    logic       slaveEn = 1'b0;
    logic [7:0] slaveByte = 8'hFF;
    int         slaveIdx = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor plus a touch-style slave on channel 0: presence after a long low,
    // and a 30 us pull in any slot whose slave bit is 0.
    initial begin : busModel
        logic [7:0] drv8, prev8;
        int lowStart, pullUntil, presStart, presEnd, idxAtFall, slaveFall;
        prev8 = '0; lowStart = 0; pullUntil = 0; presStart = 0; presEnd = 0;
        idxAtFall = 0; slaveFall = 0;
        slavePull = '0;
        forever begin
            @(negedge clock29M);
            drv8 = 8'(busDriveLow);
            for (int i = 0; i < CHANNELS; i++) begin
                if (i == monSel) begin
                    if (drv8[i[2:0]] && !prev8[i[2:0]]) begin
                        fallQ.push_back(cyc);
                        lowStart = cyc;
                    end
                    if (!drv8[i[2:0]] && prev8[i[2:0]]) pulseQ.push_back(cyc - lowStart);
                end else if (drv8[i[2:0]]) begin
                    otherDrive++;
                end
            end
            if (drv8[0] && !prev8[0]) begin
                slaveFall = cyc;
                idxAtFall = slaveIdx;
                if (slaveEn && !slaveByte[slaveIdx[2:0]]) pullUntil = cyc + 30*US;
                slaveIdx = (slaveIdx + 1) % 8;
            end
            if (!drv8[0] && prev8[0] && (cyc - slaveFall) >= 400*US) begin
                slaveIdx  = idxAtFall;
                presStart = cyc + 15*US;
                presEnd   = cyc + 135*US;
            end
            slavePull[0] = slaveEn && ((cyc < pullUntil) || (cyc >= presStart && cyc < presEnd));
            prev8 = drv8;
        end
    end

    task automatic runCmd(input string name, input logic [1:0] op, input logic [2:0] ch,
                          input logic [7:0] data, input int pokeAt);
        int         accCyc, latency, lo, hi, nBits;
        bit         seen;
        logic [7:0] tx, slaveBits, fl8, expData, gotData;
        logic       expPres, expErr, gotPres, gotErr;
        int         expPulses[$];

        fl8       = 8'(forceLow);
        slaveBits = (ch == 3'd0 && slaveEn) ? slaveByte : 8'hFF;
        expData = '0; expPres = 1'b0; expErr = 1'b0; lo = 1; hi = 2*US + 2;
        gotData = '0; gotPres = 1'b0; gotErr = 1'b0; latency = -1; seen = 1'b0;
        if (int'(ch) >= CHANNELS) begin
            expErr = 1'b1; lo = 2; hi = 2;
        end else if (op == 2'd0) begin
            if (fl8[ch]) expErr = 1'b1;
            else begin
                expPulses.push_back(480*US);
                expPres = (ch == 3'd0) && slaveEn;
                lo = 960*US; hi = lo + 2*US + 2;
            end
        end else begin
            nBits = (op == 2'd3) ? 1 : 8;
            tx = (op == 2'd1) ? data : (op == 2'd2) ? 8'hFF : {7'b0, data[0]};
            for (int k = 0; k < nBits; k++) expPulses.push_back(tx[k[2:0]] ? 6*US : 60*US);
            expData = tx & slaveBits;
            lo = nBits*71*US; hi = lo + 2*US + 2;
        end

        @(negedge clock29M);
        pulseQ.delete(); fallQ.delete(); otherDrive = 0; monSel = int'(ch); slaveIdx = 0;
        checkVal({name, " ready"}, 32'(host.cmdReady), 1);
        host.cmdValid = 1'b1; host.cmdOp = op_t'(op); host.cmdChannel = ch; host.cmdData = data;
        accCyc = cyc;
        @(negedge clock29M);
        host.cmdValid   = 1'b0;
        host.cmdOp      = op_t'($urandom_range(3, 0));
        host.cmdChannel = 3'($urandom);
        host.cmdData    = 8'($urandom);
        checkVal({name, " busy"}, 32'(host.cmdReady), 0);
        while (!seen && (cyc - accCyc) < 1100*US) begin
            if (host.respValid) begin
                seen = 1'b1; latency = cyc - accCyc;
                gotData = host.respData; gotPres = host.respPresence; gotErr = host.respError;
            end else begin
                host.cmdValid = (pokeAt > 0) && ((cyc - accCyc) == pokeAt);
                if (host.cmdValid) begin
                    host.cmdOp = OP_TOUCH_BIT; host.cmdChannel = 3'd0; host.cmdData = 8'h00;
                end
                @(negedge clock29M);
            end
        end
        host.cmdValid = 1'b0;
        checkVal({name, " resp seen"}, 32'(seen), 1);
        checkVal({name, " latency"}, (latency >= lo && latency <= hi) ? lo : latency, lo);
        checkVal({name, " data"}, 32'(gotData), 32'(expData));
        checkVal({name, " presence"}, 32'(gotPres), 32'(expPres));
        checkVal({name, " error"}, 32'(gotErr), 32'(expErr));
        @(negedge clock29M);
        checkVal({name, " valid one cycle"}, 32'(host.respValid), 0);
        checkVal({name, " ready after"}, 32'(host.cmdReady), 1);
        checkVal({name, " pulse count"}, pulseQ.size(), expPulses.size());
        foreach (expPulses[k])
            if (k < pulseQ.size())
                checkVal($sformatf("%s pulse%0d", name, k), pulseQ[k], expPulses[k]);
        for (int k = 1; k < fallQ.size(); k++)
            checkVal($sformatf("%s period%0d", name, k), fallQ[k] - fallQ[k-1], 71*US);
        checkVal({name, " other channels quiet"}, otherDrive, 0);
    endtask

    initial begin
        int  respCount;
        bit  sawDrive;
        logic [1:0] rop;
        logic [2:0] rch;

        reset = 1'b1; forceLow = '0;
        host.cmdValid = 1'b0; host.cmdOp = OP_RESET; host.cmdChannel = '0; host.cmdData = '0;
        repeat (3) @(negedge clock29M);
        checkVal("reset cmdReady", 32'(host.cmdReady), 1);
        checkVal("reset respValid", 32'(host.respValid), 0);
        checkVal("reset respData", 32'(host.respData), 0);
        checkVal("reset respPresence", 32'(host.respPresence), 0);
        checkVal("reset respError", 32'(host.respError), 0);
        checkVal("reset busDriveLow", 32'(busDriveLow), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock29M);

        slaveEn = 1'b1; slaveByte = 8'hFF;
        runCmd("reset_ch0_presence", 2'd0, 3'd0, 8'h00, 0);
        runCmd("reset_ch1_nopresence_poke", 2'd0, 3'd1, 8'h00, 100);
        runCmd("write_a5_ch1", 2'd1, 3'd1, 8'hA5, 0);
        slaveByte = 8'h3C;
        runCmd("read_3c_ch0", 2'd2, 3'd0, 8'h00, 0);
        runCmd("bad_channel", 2'd1, 3'd5, 8'h55, 0);

        forceLow[0] = 1'b1;
        repeat (5) @(negedge clock29M);
        runCmd("reset_line_short", 2'd0, 3'd0, 8'h00, 0);
        forceLow[0] = 1'b0;
        repeat (5) @(negedge clock29M);

        // Abort a write in the middle of its first low phase.
        monSel = 0; slaveIdx = 0; sawDrive = 1'b0;
        @(negedge clock29M);
        host.cmdValid = 1'b1; host.cmdOp = OP_WRITE_BYTE; host.cmdChannel = 3'd0; host.cmdData = 8'h00;
        @(negedge clock29M);
        host.cmdValid = 1'b0;
        for (int n = 0; n < 4*US && !sawDrive; n++) begin
            if (busDriveLow[0]) sawDrive = 1'b1;
            else @(negedge clock29M);
        end
        checkVal("abort drive started", 32'(sawDrive), 1);
        repeat (10) @(negedge clock29M);
        reset = 1'b1;
        @(negedge clock29M);
        checkVal("abort busDriveLow", 32'(busDriveLow), 0);
        checkVal("abort cmdReady", 32'(host.cmdReady), 1);
        checkVal("abort respValid", 32'(host.respValid), 0);
        checkVal("abort respData", 32'(host.respData), 0);
        reset = 1'b0;
        respCount = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock29M);
            if (host.respValid) respCount++;
        end
        checkVal("abort no response", respCount, 0);

        for (int r = 0; r < 8; r++) begin
            rop = 2'($urandom_range(3, 1));
            rch = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 2)) : 3'($urandom_range(1, 0));
            slaveByte = 8'($urandom);
            runCmd($sformatf("rand%0d_op%0d_ch%0d", r, rop, rch), rop, rch, 8'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onewire_master.md
Name: onewire_master

Overview:
- Hardware 1-wire timing engine that replaces host bit-banging of the DS2433/DS2401 lines.
- Parametrised over channel count. Executes reset/presence, byte write, byte read and single-bit touch on one selected channel per command, with all slot timing generated in hardware.
- Sits behind the FPGA host register decoder. Command and response are latched by register glue, and the open-drain pads are driven from busDriveLow.

Parameters:
- CHANNELS, 2, number of independent 1-wire buses (1..8).
- CLOCK_FREQ, 29491200, clock29M frequency in Hz. US_CYCLES = CLOCK_FREQ/1000000, truncated (29 at default).
- CHANNEL_BITS, 3, width of the channel select field.

Ports:
- clock29M  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmdValid  in  1  command request.
- cmdReady  out  1  engine idle and accepting a command.
- cmdOp  in  2  0=RESET, 1=WRITE_BYTE, 2=READ_BYTE, 3=TOUCH_BIT.
- cmdChannel  in  CHANNEL_BITS  target bus.
- cmdData  in  8  byte to write; bit 0 is used for TOUCH_BIT.
- respValid  out  1  one-cycle completion pulse.
- respData  out  8  read byte, or the touched bit in bit 0; holds until the next response.
- respPresence  out  1  presence pulse detected (RESET only).
- respError  out  1  bad channel, or line held low at reset start.
- busDriveLow  out  CHANNELS  1 = pull bus low; top level maps this to 0/z.
- busIn  in  CHANNELS  raw pad state, asynchronous.

Behaviour:
- Reset state: busDriveLow all 0 (released), cmdReady=1, respValid=0, respData=0, respPresence=0, respError=0, FSM IDLE.
- Reset is also honoured mid-operation: line released on the next edge. No respValid is produced for the aborted command.
- busIn passes through a 2-FF synchroniser per channel. All samples use the synchronised value (2-cycle latency). Timing targets below include this latency.
- Microsecond tick: a 1-cycle pulse every US_CYCLES clocks. It restarts at command acceptance, so the first tick arrives exactly US_CYCLES after acceptance. A 10-bit usCount counts ticks within each phase.
- Handshake: command accepted on a cycle where cmdValid & cmdReady. cmdReady drops on the next cycle and stays low until the cycle after respValid. cmdValid while busy is ignored; nothing is queued.
- Command fields (op, channel, data) are captured at acceptance. Later input changes have no effect.
- Invalid channel (cmdChannel >= CHANNELS): no bus activity. respValid with respError=1 two cycles after acceptance.
- FSM states: IDLE, CHECK, RST_LOW, RST_WAIT, RST_RECOVER, SLOT_LOW, SLOT_SAMPLE, SLOT_RECOVER, DONE.
- CHECK (RESET only): if the synchronised line is low, go to DONE with respError=1 (bus short). Otherwise go to RST_LOW.
- RST_LOW: drive low for 480 us.
- RST_WAIT: release. At 70 us, latch respPresence = ~busIn.
- RST_RECOVER: a further 410 us, then DONE.
- Bit slots: WRITE_BYTE and READ_BYTE run 8 slots, LSB first, using a 3-bit bitIndex. TOUCH_BIT runs 1 slot.
- SLOT_LOW: drive low for 6 us for a write-1 or any read slot; for 60 us for a write-0.
- SLOT_SAMPLE: release. At 9 us after release, shift in the synchronised busIn. Read slots and TOUCH_BIT with data=1 always sample; write slots also sample, which enables touch semantics.
- SLOT_RECOVER: pad the slot so total slot time is 70 us, then +1 us recovery. After that, go to the next bit or to DONE.
- The write-0 path skips SLOT_SAMPLE's wait beyond the slot end but still records the sampled value (0).
- READ_BYTE and TOUCH_BIT transmit 1s (cmdData ignored for READ_BYTE).
- DONE: respValid=1 for one cycle, then IDLE. respData = shifted byte (TOUCH_BIT: {7'b0, sample}). respPresence and respError are cleared at each acceptance.
- Only the selected channel is ever driven. All other busDriveLow bits stay 0 throughout.

Decomposition:
- Package onewire_pkg: op codes; state enum; timing constants RESET_LOW_US=480, PRESENCE_SAMPLE_US=70, RESET_RECOVER_US=410, SLOT_LOW1_US=6, SLOT_LOW0_US=60, SAMPLE_US=9, SLOT_US=70, RECOVERY_US=1.
- One sub-module, onewire_us_tick: the prescaler with a restart input, parametrised by CLOCK_FREQ.

Test Plan:
- RESET on channel 0, slave model pulls low from 15 us to 135 us after release -> busDriveLow[0] high for exactly 480x29=13920 cycles. respPresence=1, respError=0, respValid about 960 us after acceptance.
- RESET on channel 1 with no slave -> respPresence=0. busDriveLow[0] stays 0 for the whole run.
- WRITE_BYTE 0xA5 -> low pulses of LSB-first pattern 6,60,6,60,60,6,60,6 us (multiples of 29 cycles). Slot period 71 us. respData=0xA5 with a passive bus.
- READ_BYTE, slave drives 0x3C -> all slots 6 us low. respData=0x3C.
- cmdChannel=5 with CHANNELS=2 -> no bus toggle. respError=1 and respValid 2 cycles after acceptance. A cmdValid pulse during a busy RESET is ignored.
- Line forced low, then RESET -> respError=1, no drive. Separately, assert reset mid WRITE_BYTE -> busDriveLow=0 next cycle, cmdReady=1, no respValid.
